// File: rtl/ecc_24_rd_sink_if.sv
// Word handshake bundle between the SECDED decoder, the read sink and the downstream consumer.
interface ecc_24_rd_sink_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [23:0]           in_data;
  logic                  in_sbit_err;
  logic                  in_dbit_err;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  out_vld;
  logic                  out_rdy;
  logic [23:0]           out_data;
  logic                  out_derr;

  modport master (
    output in_vld, in_data, in_sbit_err, in_dbit_err, in_addr, out_rdy,
    input  in_rdy, out_vld, out_data, out_derr
  );

  modport slave (
    input  in_vld, in_data, in_sbit_err, in_dbit_err, in_addr, out_rdy,
    output in_rdy, out_vld, out_data, out_derr
  );
endinterface

// File: rtl/ecc_24_rd_sink.sv
// Read-side ECC sink: 2-entry skid buffer, saturating error counters, sticky irq.
// Optional first-error address log enabled by defining ECC_RD_SINK_ADDR_LOG_EN.
module ecc_24_rd_sink #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ecc_24_rd_sink_if.slave       bus,
  input  logic [CNT_WIDTH-1:0]  sbit_thr,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic                  ecc_irq,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_addr_vld
);
  localparam int unsigned DATA_W = 24;

  typedef struct packed {
    logic              derr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [1:0]           r_cnt;
  entry_t               r_head;
  entry_t               r_tail;
  logic                 r_in_rdy;
  logic                 r_out_vld;
  logic [CNT_WIDTH-1:0] r_sbit_cnt;
  logic [CNT_WIDTH-1:0] r_dbit_cnt;
  logic                 r_irq;

  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_cnt_nxt;
  logic                 w_wr_head;
  logic                 w_wr_tail;
  logic                 w_shift;
  entry_t               w_in_ent;
  logic                 w_sev;
  logic                 w_dev;
  logic [CNT_WIDTH-1:0] w_sbase;
  logic [CNT_WIDTH-1:0] w_dbase;
  logic [CNT_WIDTH-1:0] w_s_nxt;
  logic [CNT_WIDTH-1:0] w_d_nxt;
  logic                 w_irq_nxt;

  // Buffer control: head is always the oldest entry, tail only used when two are held.
  always_comb begin
    w_push    = bus.in_vld & r_in_rdy;
    w_pop     = r_out_vld & bus.out_rdy;
    w_in_ent  = '{derr: bus.in_dbit_err, data: bus.in_data};
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - 2'd1;
    end
    w_wr_head = w_push & ((r_cnt == 2'd0) | ((r_cnt == 2'd1) & w_pop));
    w_wr_tail = w_push & (r_cnt == 2'd1) & ~w_pop;
    w_shift   = w_pop & (r_cnt == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 2'd0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_head    <= '0;
      r_tail    <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_in_rdy  <= (w_cnt_nxt != 2'd2);
      r_out_vld <= (w_cnt_nxt != 2'd0);
      if (w_wr_head) begin
        r_head <= w_in_ent;
      end else if (w_shift) begin
        r_head <= r_tail;
      end
      if (w_wr_tail) begin
        r_tail <= w_in_ent;
      end
    end
  end

  // Error accounting; a clear in the same cycle is applied before the event.
  always_comb begin
    w_sev     = w_push & bus.in_sbit_err & ~bus.in_dbit_err;
    w_dev     = w_push & bus.in_dbit_err;
    w_sbase   = cnt_clr ? '0 : r_sbit_cnt;
    w_dbase   = cnt_clr ? '0 : r_dbit_cnt;
    w_s_nxt   = (w_sev && (w_sbase != '1)) ? w_sbase + CNT_WIDTH'(1) : w_sbase;
    w_d_nxt   = (w_dev && (w_dbase != '1)) ? w_dbase + CNT_WIDTH'(1) : w_dbase;
    w_irq_nxt = (~cnt_clr & r_irq) | w_dev
              | (w_sev & (sbit_thr != '0) & (w_s_nxt == sbit_thr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sbit_cnt <= '0;
      r_dbit_cnt <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sbit_cnt <= w_s_nxt;
      r_dbit_cnt <= w_d_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

`ifdef ECC_RD_SINK_ADDR_LOG_EN
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_addr_vld;
  logic                  w_av_base;

  always_comb begin
    w_av_base = ~cnt_clr & r_err_addr_vld;
  end

  // First error since clear wins; later errors leave the capture alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_addr     <= '0;
      r_err_addr_vld <= 1'b0;
    end else if ((w_sev || w_dev) && !w_av_base) begin
      r_err_addr     <= bus.in_addr;
      r_err_addr_vld <= 1'b1;
    end else begin
      r_err_addr_vld <= w_av_base;
    end
  end

  assign err_addr     = r_err_addr;
  assign err_addr_vld = r_err_addr_vld;
`else
  logic w_addr_unused;
  assign w_addr_unused = ^bus.in_addr;
  assign err_addr      = '0;
  assign err_addr_vld  = 1'b0;
`endif

  assign bus.in_rdy   = r_in_rdy;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_data = r_head.data;
  assign bus.out_derr = r_head.derr;
  assign sbit_cnt     = r_sbit_cnt;
  assign dbit_cnt     = r_dbit_cnt;
  assign ecc_irq      = r_irq;
endmodule

// File: tb/tb_ecc_24_rd_sink.sv
// Bench for ecc_24_rd_sink: directed table, hand sequences and random traffic vs a queue model.
module tb_ecc_24_rd_sink;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 8;
  localparam int MAXC = 255;
`ifdef ECC_RD_SINK_ADDR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ecc_24_rd_sink_if #(.ADDR_WIDTH(AW)) bus();
  logic [CW-1:0] sbit_thr;
  logic          cnt_clr;
  logic [CW-1:0] sbit_cnt;
  logic [CW-1:0] dbit_cnt;
  logic          ecc_irq;
  logic [AW-1:0] err_addr;
  logic          err_addr_vld;

  ecc_24_rd_sink #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sbit_thr(sbit_thr), .cnt_clr(cnt_clr),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .ecc_irq(ecc_irq),
    .err_addr(err_addr), .err_addr_vld(err_addr_vld)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain FIFO queue plus integer counters.
  logic [24:0] m_q[$];
  bit          m_rdy;
  int          m_s, m_d;
  bit          m_irq, m_av;
  logic [7:0]  m_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [23:0] d, input logic s, input logic db,
                       input logic [7:0] a, input logic ordy, input logic clr);
    bus.in_vld = vld; bus.in_data = d; bus.in_sbit_err = s; bus.in_dbit_err = db;
    bus.in_addr = a; bus.out_rdy = ordy; cnt_clr = clr;
  endtask

  task automatic model_step();
    bit push, pop, se, de;
    if (!rst_n) begin
      m_q.delete(); m_rdy = 0; m_s = 0; m_d = 0; m_irq = 0; m_av = 0; m_addr = '0;
    end else begin
      push = bus.in_vld && m_rdy;
      pop  = (m_q.size() != 0) && bus.out_rdy;
      de   = push && bus.in_dbit_err;
      se   = push && bus.in_sbit_err && !bus.in_dbit_err;
      if (cnt_clr) begin m_s = 0; m_d = 0; m_irq = 0; m_av = 0; end
      if (se && m_s < MAXC) m_s++;
      if (de && m_d < MAXC) m_d++;
      if (de) m_irq = 1;
      if (se && sbit_thr != 0 && m_s == int'(sbit_thr)) m_irq = 1;
      if (LOG && (se || de) && !m_av) begin m_addr = bus.in_addr; m_av = 1; end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({bus.in_dbit_err, bus.in_data});
      m_rdy = (m_q.size() != 2);
    end
  endtask

  task automatic check_model();
    logic [24:0] h;
    chk("m_in_rdy", 32'(bus.in_rdy), 32'(m_rdy));
    chk("m_out_vld", 32'(bus.out_vld), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      h = m_q[0];
      chk("m_out_data", 32'(bus.out_data), 32'(h[23:0]));
      chk("m_out_derr", 32'(bus.out_derr), 32'(h[24]));
    end
    chk("m_sbit_cnt", 32'(sbit_cnt), 32'(m_s));
    chk("m_dbit_cnt", 32'(dbit_cnt), 32'(m_d));
    chk("m_irq", 32'(ecc_irq), 32'(m_irq));
    chk("m_addr_vld", 32'(err_addr_vld), 32'(m_av));
    chk("m_addr", 32'(err_addr), 32'(m_addr));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic vld; logic [23:0] data; logic sbit, dbit; logic [7:0] addr;
    logic ordy, clr; logic [7:0] thr;
    logic e_rdy, e_ovld; logic [23:0] e_data; logic e_derr;
    logic [7:0] e_s, e_d; logic e_irq, e_av; logic [7:0] e_addr;
  } vec_t;

  function automatic vec_t mk(logic vld, logic [23:0] data, logic sbit, logic dbit, logic [7:0] addr,
                              logic ordy, logic clr, logic [7:0] thr, logic e_rdy, logic e_ovld,
                              logic [23:0] e_data, logic e_derr, logic [7:0] e_s, logic [7:0] e_d,
                              logic e_irq, logic e_av, logic [7:0] e_addr);
    vec_t v;
    v.vld = vld; v.data = data; v.sbit = sbit; v.dbit = dbit; v.addr = addr;
    v.ordy = ordy; v.clr = clr; v.thr = thr; v.e_rdy = e_rdy; v.e_ovld = e_ovld;
    v.e_data = e_data; v.e_derr = e_derr; v.e_s = e_s; v.e_d = e_d;
    v.e_irq = e_irq; v.e_av = e_av; v.e_addr = e_addr;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [7:0] a20, a5a;
    a20 = LOG ? 8'h20 : 8'h00;
    a5a = LOG ? 8'h5A : 8'h00;
    // Stall with three words offered, then drain.
    tbl[0]  = mk(1, 24'hA00001, 0, 0, 8'h00, 0, 0, 0,  1, 1, 24'hA00001, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 24'hA00002, 0, 0, 8'h00, 0, 0, 0,  0, 1, 24'hA00001, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 24'hA00003, 0, 0, 8'h00, 0, 0, 0,  0, 1, 24'hA00001, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 24'hA00003, 0, 0, 8'h00, 1, 0, 0,  1, 1, 24'hA00002, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 24'hA00003, 0, 0, 8'h00, 1, 0, 0,  1, 1, 24'hA00003, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 24'h000000, 0, 0, 8'h00, 1, 0, 0,  1, 0, 24'h000000, 0, 0, 0, 0, 0, 0);
    // Single-bit threshold of 3.
    tbl[6]  = mk(1, 24'hB00001, 1, 0, 8'h20, 1, 0, 3,  1, 1, 24'hB00001, 0, 1, 0, 0, LOG, a20);
    tbl[7]  = mk(1, 24'hB00002, 1, 0, 8'h21, 1, 0, 3,  1, 1, 24'hB00002, 0, 2, 0, 0, LOG, a20);
    tbl[8]  = mk(1, 24'hB00003, 1, 0, 8'h22, 1, 0, 3,  1, 1, 24'hB00003, 0, 3, 0, 1, LOG, a20);
    tbl[9]  = mk(1, 24'hB00004, 1, 0, 8'h23, 1, 0, 3,  1, 1, 24'hB00004, 0, 4, 0, 1, LOG, a20);
    tbl[10] = mk(0, 24'h000000, 0, 0, 8'h00, 1, 0, 3,  1, 0, 24'h000000, 0, 4, 0, 1, LOG, a20);
    // Clear, then double-bit at 5A and single-bit at 10.
    tbl[11] = mk(0, 24'h000000, 0, 0, 8'h00, 1, 1, 0,  1, 0, 24'h000000, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 24'hC00001, 0, 1, 8'h5A, 1, 0, 0,  1, 1, 24'hC00001, 1, 0, 1, 1, LOG, a5a);
    tbl[13] = mk(1, 24'hD00001, 1, 0, 8'h10, 1, 0, 0,  1, 1, 24'hD00001, 0, 1, 1, 1, LOG, a5a);
    tbl[14] = mk(0, 24'h000000, 0, 0, 8'h00, 1, 0, 0,  1, 0, 24'h000000, 0, 1, 1, 1, LOG, a5a);

    // Reset state.
    rst_n = 1'b0; sbit_thr = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("rst_in_rdy", 32'(bus.in_rdy), 0);
    chk("rst_out_vld", 32'(bus.out_vld), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_derr", 32'(bus.out_derr), 0);
    chk("rst_cnts", 32'({sbit_cnt, dbit_cnt}), 0);
    chk("rst_irq_log", 32'({ecc_irq, err_addr_vld, err_addr}), 0);
    rst_n = 1'b1;
    step();
    chk("rdy_after_rst", 32'(bus.in_rdy), 1);

    // Ten clean words back to back.
    for (int i = 0; i < 10; i++) begin
      drive(1, 24'(24'h100 + i), 0, 0, 8'(i), 1, 0);
      step();
      chk("clean_rdy", 32'(bus.in_rdy), 1);
      chk("clean_vld", 32'(bus.out_vld), 1);
      chk("clean_data", 32'(bus.out_data), 32'(24'h100 + i));
      chk("clean_cnt", 32'(sbit_cnt), 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    chk("clean_drained", 32'(bus.out_vld), 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].sbit, tbl[i].dbit, tbl[i].addr, tbl[i].ordy, tbl[i].clr);
      sbit_thr = tbl[i].thr;
      step();
      chk("tbl_in_rdy", 32'(bus.in_rdy), 32'(tbl[i].e_rdy));
      chk("tbl_out_vld", 32'(bus.out_vld), 32'(tbl[i].e_ovld));
      if (tbl[i].e_ovld) begin
        chk("tbl_out_data", 32'(bus.out_data), 32'(tbl[i].e_data));
        chk("tbl_out_derr", 32'(bus.out_derr), 32'(tbl[i].e_derr));
      end
      chk("tbl_sbit_cnt", 32'(sbit_cnt), 32'(tbl[i].e_s));
      chk("tbl_dbit_cnt", 32'(dbit_cnt), 32'(tbl[i].e_d));
      chk("tbl_irq", 32'(ecc_irq), 32'(tbl[i].e_irq));
      chk("tbl_addr_vld", 32'(err_addr_vld), 32'(tbl[i].e_av));
      if (tbl[i].e_av) chk("tbl_addr", 32'(err_addr), 32'(tbl[i].e_addr));
    end
    sbit_thr = '0;

    // Saturation, then clear coincident with a single-bit push.
    for (int i = 0; i < 300; i++) begin
      drive(1, 24'($urandom), 1, 0, 8'(i), 1, 0);
      step();
    end
    chk("sat_sbit", 32'(sbit_cnt), 255);
    drive(1, 24'h123456, 1, 0, 8'h44, 1, 1);
    step();
    chk("clr_push_sbit", 32'(sbit_cnt), 1);
    chk("clr_push_dbit", 32'(dbit_cnt), 0);
    chk("clr_push_irq", 32'(ecc_irq), 0);

    // Reset with two entries buffered.
    drive(1, 24'hE00001, 1, 0, 8'h01, 0, 0);
    step();
    drive(1, 24'hE00002, 0, 0, 8'h02, 0, 0);
    step();
    chk("pre_rst_full", 32'({bus.out_vld, bus.in_rdy}), 32'(2'b10));
    rst_n = 1'b0;
    drive(1, 24'hE00003, 0, 1, 8'h03, 1, 0);
    step();
    chk("midrst_vld", 32'(bus.out_vld), 0);
    chk("midrst_rdy", 32'(bus.in_rdy), 0);
    chk("midrst_cnts", 32'({sbit_cnt, dbit_cnt}), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 24'hF00001, 0, 0, 8'h00, 1, 0);
    step();
    chk("resume_data", 32'({bus.out_vld, bus.out_data}), 32'({1'b1, 24'hF00001}));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int e;
      e = int'($urandom_range(0, 7));
      drive(($urandom % 4) != 0, 24'($urandom), (e == 0) || (e == 2), (e == 1) || (e == 2),
            8'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0);
      if (i % 500 == 0) sbit_thr = 8'($urandom_range(0, 6));
      rst_n = ($urandom % 400) != 0;
      step();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
